// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller and playfield datapath.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } gameState_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int unsigned CELL_SIZE = 20;
  localparam int unsigned PERIOD_W  = 27;

  // Move period for a level: base minus level*step, floored at minTick.
  function automatic logic [PERIOD_W-1:0] movePeriod(
    input logic [2:0]  lvl,
    input int unsigned base,
    input int unsigned step,
    input int unsigned minTick
  );
    int unsigned dec;
    int unsigned per;
    dec = 32'(lvl) * step;
    if (dec > base || (base - dec) < minTick) per = minTick;
    else per = base - dec;
    return PERIOD_W'(per);
  endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Controller <-> datapath/buttons signal bundle.
interface snake_game_ctrl_if #(
  parameter int unsigned SCORE_W = 10
);
  logic               Go;
  logic               PauseBtn;
  logic [3:0]         dir_req;
  logic               gameOver;
  logic               apple_eaten;
  logic               move_tick;
  logic [1:0]         dir;
  logic               running;
  logic               game_clr;
  logic [SCORE_W-1:0] score;
  logic [2:0]         level;

  modport master (
    input  Go, PauseBtn, dir_req, gameOver, apple_eaten,
    output move_tick, dir, running, game_clr, score, level
  );

  modport slave (
    output Go, PauseBtn, dir_req, gameOver, apple_eaten,
    input  move_tick, dir, running, game_clr, score, level
  );
endinterface

// File: rtl/snake_tick_gen.sv
// Move-period counter: counts 0..period-1 while enabled and flags the wrap.
module snake_tick_gen
  import snake_pkg::*;
(
  input  logic                CLK_100MHz,
  input  logic                Reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] curPeriod;
  logic                wrap;

  // Wrap when the last count of the latched period is reached.
  always_comb begin
    wrap = enable && (count == curPeriod - 1'b1);
    tick = wrap;
  end

  // Period is latched only at clear/wrap so a level change takes effect
  // from the next wrap instead of mid-period.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      count     <= '0;
      curPeriod <= period;
    end else if (clear) begin
      count     <= '0;
      curPeriod <= period;
    end else if (wrap) begin
      count     <= '0;
      curPeriod <= period;
    end else if (enable) begin
      count     <= count + 1'b1;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-flow controller: run/pause/over FSM, move strobe, direction
// arbitration, score and level keeping.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned TICK_BASE        = 10_000_000,
  parameter int unsigned TICK_STEP        = 1_000_000,
  parameter int unsigned MIN_TICK         = 2_000_000,
  parameter int unsigned APPLES_PER_LEVEL = 5,
  parameter int unsigned LEVEL_MAX        = 7,
  parameter int unsigned SCORE_W          = 10
) (
  input logic               CLK_100MHz,
  input logic               Reset,
  snake_game_ctrl_if.master bus
);

  localparam int unsigned APPLE_W = $clog2(APPLES_PER_LEVEL + 1);

  gameState_t          state;
  logic                goPrev;
  logic                pausePrev;
  logic [1:0]          pending;
  logic [1:0]          dirReg;
  logic [SCORE_W-1:0]  scoreReg;
  logic [2:0]          levelReg;
  logic [APPLE_W-1:0]  appleCnt;
  logic                moveTickReg;
  logic                runningReg;
  logic                gameClrReg;

  logic                goRise;
  logic                pauseRise;
  logic                tickEn;
  logic                tickClr;
  logic                wrap;
  logic                reqValid;
  logic [1:0]          reqDir;
  logic                appleHit;
  logic [PERIOD_W-1:0] curPeriod;

  // Button edges, tick control and direction request arbitration.
  always_comb begin
    goRise    = bus.Go && !goPrev;
    pauseRise = bus.PauseBtn && !pausePrev;
    // Counter is frozen on any cycle the FSM leaves RUN, so no strobe escapes.
    tickEn    = (state == RUN) && !bus.gameOver && !pauseRise;
    tickClr   = (state == IDLE) || (state == OVER);
    appleHit  = bus.apple_eaten && !bus.gameOver;
    curPeriod = movePeriod(levelReg, TICK_BASE, TICK_STEP, MIN_TICK);
    reqValid  = 1'b1;
    reqDir    = DIR_UP;
    if (bus.dir_req[0])      reqDir = DIR_UP;
    else if (bus.dir_req[1]) reqDir = DIR_RIGHT;
    else if (bus.dir_req[2]) reqDir = DIR_DOWN;
    else if (bus.dir_req[3]) reqDir = DIR_LEFT;
    else                     reqValid = 1'b0;
    if (reqDir == (dirReg ^ 2'b10)) reqValid = 1'b0;
  end

  snake_tick_gen u_tickGen (
    .CLK_100MHz (CLK_100MHz),
    .Reset      (Reset),
    .enable     (tickEn),
    .clear      (tickClr),
    .period     (curPeriod),
    .tick       (wrap)
  );

  // Game FSM with registered outputs, score/level and direction commit.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      state       <= IDLE;
      goPrev      <= 1'b1;
      pausePrev   <= 1'b1;
      pending     <= DIR_RIGHT;
      dirReg      <= DIR_RIGHT;
      scoreReg    <= '0;
      levelReg    <= '0;
      appleCnt    <= '0;
      moveTickReg <= 1'b0;
      runningReg  <= 1'b0;
      gameClrReg  <= 1'b0;
    end else begin
      goPrev      <= bus.Go;
      pausePrev   <= bus.PauseBtn;
      moveTickReg <= wrap;
      gameClrReg  <= 1'b0;
      if (wrap) dirReg <= pending;
      unique case (state)
        IDLE: begin
          if (goRise) begin
            state      <= RUN;
            runningReg <= 1'b1;
          end
        end
        RUN: begin
          if (reqValid) pending <= reqDir;
          if (appleHit) begin
            if (scoreReg != '1) scoreReg <= scoreReg + 1'b1;
            if (appleCnt == APPLE_W'(APPLES_PER_LEVEL - 1)) begin
              appleCnt <= '0;
              if (levelReg != 3'(LEVEL_MAX)) levelReg <= levelReg + 1'b1;
            end else begin
              appleCnt <= appleCnt + 1'b1;
            end
          end
          if (bus.gameOver) begin
            state      <= OVER;
            runningReg <= 1'b0;
          end else if (pauseRise) begin
            state      <= PAUSE;
            runningReg <= 1'b0;
          end
        end
        PAUSE: begin
          if (goRise || pauseRise) begin
            state      <= RUN;
            runningReg <= 1'b1;
          end
        end
        OVER: begin
          if (goRise) begin
            state      <= IDLE;
            gameClrReg <= 1'b1;
            scoreReg   <= '0;
            levelReg   <= '0;
            appleCnt   <= '0;
            dirReg     <= DIR_RIGHT;
            pending    <= DIR_RIGHT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.move_tick = moveTickReg;
  assign bus.dir       = dirReg;
  assign bus.running   = runningReg;
  assign bus.game_clr  = gameClrReg;
  assign bus.score     = scoreReg;
  assign bus.level     = levelReg;

endmodule
